// File: rtl/ifstage_fetch.sv
// rtl/ifstage_fetch.sv - instruction fetch stage: PC register, imem request/ack handshake, fetch timeout
//
// Holds the program counter and fetches one instruction per PC.
// After reset the stage issues its first request.
// It then waits for Imem_Ack, with a bounded timeout.
// It then presents the word on Instr with Instr_Valid set.
// It stays there until the decode stage asks for the next PC through PC_LdEn.
//
// Parameters
//   RESET_PC     PC value loaded on reset
//   TIMEOUT      cycles waited for Imem_Ack before Fetch_Err (2..255)
// Ports
//   Clk          clock, rising edge
//   Reset        asynchronous active-high reset
//   PC_Immed     branch offset (pre sign-extended, pre shifted by 2)
//   PC_sel       0: PC+4, 1: PC+4+PC_Immed
//   PC_LdEn      advance PC and start the next fetch (honoured only once a fetch is complete)
//   Imem_Ack     instruction memory data valid
//   Imem_Data    instruction word, valid with Imem_Ack
//   Imem_Req     registered fetch request
//   Imem_Addr    fetch address, always equal to PC
//   PC           current program counter
//   Instr        registered instruction word
//   Instr_Valid  Instr holds the word fetched from the current PC
//   Fetch_Err    sticky fetch-timeout flag
module ifstage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PC_Immed,
    input  logic        PC_sel,
    input  logic        PC_LdEn,
    input  logic        Imem_Ack,
    input  logic [31:0] Imem_Data,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    output logic [31:0] PC,
    output logic [31:0] Instr,
    output logic        Instr_Valid,
    output logic        Fetch_Err
);

    localparam logic [1:0] S_START = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    // The last wait count at which a missing Ack is still tolerated.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  wait_cnt;
    logic [31:0] pc_offset;
    logic [31:0] pc_next;

    // Modulo-2^32 sum. The low two bits are masked so that a malformed offset cannot misalign the PC.
    assign pc_offset = PC_sel ? PC_Immed : 32'd0;
    assign pc_next   = (PC + 32'd4 + pc_offset) & 32'hFFFF_FFFC;
    assign Imem_Addr = PC;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_START;
            PC          <= RESET_PC & 32'hFFFF_FFFC;
            Instr       <= 32'd0;
            Instr_Valid <= 1'b0;
            Imem_Req    <= 1'b0;
            Fetch_Err   <= 1'b0;
            wait_cnt    <= 8'd0;
        end else begin
            case (state)
                S_START: begin
                    state    <= S_REQ;
                    Imem_Req <= 1'b1;
                    wait_cnt <= 8'd0;
                end
                S_REQ: begin
                    // Ack is honoured even on the first request cycle, so zero-wait memory completes in one cycle.
                    if (Imem_Ack) begin
                        Instr       <= Imem_Data;
                        Instr_Valid <= 1'b1;
                        Imem_Req    <= 1'b0;
                        state       <= S_DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        Fetch_Err <= 1'b1;
                        Imem_Req  <= 1'b0;
                        state     <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    // Instr keeps the old word while the new fetch is in flight; only Valid drops.
                    if (PC_LdEn) begin
                        PC          <= pc_next;
                        Instr_Valid <= 1'b0;
                        Imem_Req    <= 1'b1;
                        wait_cnt    <= 8'd0;
                        state       <= S_REQ;
                    end
                end
                default: begin
                    // S_ERR holds everything until reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifstage_fetch.sv
// tb/tb_ifstage_fetch.sv - self-checking bench for ifstage_fetch: directed vector table plus randomized model comparison
module tb_ifstage_fetch;

    localparam int TO = 5;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] PC_Immed = 32'd0;
    logic        PC_sel = 1'b0;
    logic        PC_LdEn = 1'b0;
    logic        Imem_Ack = 1'b0;
    logic [31:0] Imem_Data = 32'd0;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic        Instr_Valid;
    logic        Fetch_Err;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 Clk = ~Clk;

    ifstage_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset(Reset), .PC_Immed(PC_Immed), .PC_sel(PC_sel),
        .PC_LdEn(PC_LdEn), .Imem_Ack(Imem_Ack), .Imem_Data(Imem_Data),
        .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr), .PC(PC), .Instr(Instr),
        .Instr_Valid(Instr_Valid), .Fetch_Err(Fetch_Err)
    );

    typedef struct {
        bit          rst;
        bit          ld;
        bit          sel;
        logic [31:0] immed;
        bit          ack;
        logic [31:0] data;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        bit          e_valid;
        bit          e_req;
        bit          e_err;
    } vec_t;

    vec_t vt[$];

    function automatic void add(bit rst, bit ld, bit sel, logic [31:0] immed, bit ack,
                                logic [31:0] data, logic [31:0] e_pc, logic [31:0] e_instr,
                                bit e_valid, bit e_req, bit e_err);
        vec_t v;
        v.rst = rst; v.ld = ld; v.sel = sel; v.immed = immed; v.ack = ack; v.data = data;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_valid = e_valid; v.e_req = e_req; v.e_err = e_err;
        vt.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input bit e_valid, input bit e_req, input bit e_err);
        check({tag, " pc"}, PC, e_pc);
        check({tag, " addr"}, Imem_Addr, e_pc);
        check({tag, " instr"}, Instr, e_instr);
        check({tag, " valid"}, {31'd0, Instr_Valid}, {31'd0, e_valid});
        check({tag, " req"}, {31'd0, Imem_Req}, {31'd0, e_req});
        check({tag, " err"}, {31'd0, Fetch_Err}, {31'd0, e_err});
    endtask

    // Applied away from the clock edge; outputs sampled 1 time unit after the edge.
    task automatic drive(input bit ld, input bit sel, input logic [31:0] immed,
                         input bit ack, input logic [31:0] data);
        PC_LdEn = ld; PC_sel = sel; PC_Immed = immed; Imem_Ack = ack; Imem_Data = data;
        @(posedge Clk);
        #1;
    endtask

    // Reset pulse entirely between edges: outputs must already be at reset values while Reset is high.
    task automatic async_reset_pulse(input string tag);
        #1 Reset = 1'b1;
        #1;
        check_all(tag, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        #1 Reset = 1'b0;
    endtask

    // Reference model: tracks whether a fetch is outstanding and how many cycles it has gone unanswered.
    logic [31:0] m_pc, m_instr;
    bit          m_valid, m_err, m_started, m_busy;
    int          m_misses;

    task automatic model_reset();
        m_pc = 32'd0; m_instr = 32'd0; m_valid = 0; m_err = 0;
        m_started = 0; m_busy = 0; m_misses = 0;
    endtask

    task automatic model_edge(input bit ld, input bit sel, input logic [31:0] immed,
                              input bit ack, input logic [31:0] data);
        logic [31:0] step;
        if (m_err) begin
            // absorbing
        end else if (!m_started) begin
            m_started = 1; m_busy = 1; m_misses = 0;
        end else if (m_busy) begin
            if (ack) begin
                m_instr = data; m_valid = 1; m_busy = 0;
            end else if (m_misses + 1 == TO) begin
                m_err = 1; m_busy = 0;
            end else begin
                m_misses++;
            end
        end else if (ld) begin
            step = sel ? immed : 32'd0;
            m_pc = (m_pc + 32'd4 + step) & ~32'd3;
            m_valid = 0; m_busy = 1; m_misses = 0;
        end
    endtask

    initial begin
        // Directed table, starting from the START state after the first reset release.
        add(0,0,0,32'h0,0,32'h0,              32'h0,        32'h0,        0,1,0);
        add(0,0,0,32'h0,0,32'h0,              32'h0,        32'h0,        0,1,0);
        add(0,0,0,32'h0,1,32'hE000_0005,      32'h0,        32'hE000_0005,1,0,0);
        add(0,0,0,32'h0,1,32'h1234_5678,      32'h0,        32'hE000_0005,1,0,0);
        add(0,1,0,32'h0,0,32'h0,              32'h4,        32'hE000_0005,0,1,0);
        add(0,1,0,32'h0,0,32'h0,              32'h4,        32'hE000_0005,0,1,0);
        add(0,0,0,32'h0,1,32'h1111_1111,      32'h4,        32'h1111_1111,1,0,0);
        add(0,1,1,32'h8,0,32'h0,              32'h10,       32'h1111_1111,0,1,0);
        add(0,0,0,32'h0,1,32'h2222_2222,      32'h10,       32'h2222_2222,1,0,0);
        add(0,1,1,32'hFFFF_FFF0,0,32'h0,      32'h4,        32'h2222_2222,0,1,0);
        add(0,0,0,32'h0,1,32'h3333_3333,      32'h4,        32'h3333_3333,1,0,0);
        add(0,1,1,32'h3,0,32'h0,              32'h8,        32'h3333_3333,0,1,0);
        add(0,0,0,32'h0,1,32'h4444_4444,      32'h8,        32'h4444_4444,1,0,0);
        add(0,1,1,32'hFFFF_FFF0,0,32'h0,      32'hFFFF_FFFC,32'h4444_4444,0,1,0);
        add(0,0,0,32'h0,1,32'h5555_5555,      32'hFFFF_FFFC,32'h5555_5555,1,0,0);
        add(0,1,0,32'h0,0,32'h0,              32'h0,        32'h5555_5555,0,1,0);
        add(0,0,0,32'h0,1,32'h6666_6666,      32'h0,        32'h6666_6666,1,0,0);
        add(0,1,0,32'h0,0,32'h0,              32'h4,        32'h6666_6666,0,1,0);
        for (int i = 0; i < TO - 1; i++)
            add(0,1,0,32'h0,0,32'h0,          32'h4,        32'h6666_6666,0,1,0);
        add(0,0,0,32'h0,0,32'h0,              32'h4,        32'h6666_6666,0,0,1);
        add(0,1,1,32'h100,1,32'h77,           32'h4,        32'h6666_6666,0,0,1);
        add(0,1,0,32'h0,1,32'h77,             32'h4,        32'h6666_6666,0,0,1);
        add(1,0,0,32'h0,0,32'h0,              32'h0,        32'h0,        0,0,0);
        add(0,0,0,32'h0,1,32'h88,             32'h0,        32'h0,        0,1,0);
        add(0,1,0,32'h0,0,32'h0,              32'h0,        32'h0,        0,1,0);
        add(1,0,0,32'h0,0,32'h0,              32'h0,        32'h0,        0,0,0);
        add(0,0,0,32'h0,1,32'h99,             32'h0,        32'h0,        0,1,0);
        add(0,0,0,32'h0,1,32'hAAAA_AAAA,      32'h0,        32'hAAAA_AAAA,1,0,0);

        // Initial reset: values must appear before any clock edge.
        #1 Reset = 1'b1;
        #1;
        check_all("por", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(posedge Clk);
        #1 Reset = 1'b0;

        foreach (vt[i]) begin
            if (vt[i].rst) begin
                async_reset_pulse($sformatf("vec%0d", i));
            end else begin
                drive(vt[i].ld, vt[i].sel, vt[i].immed, vt[i].ack, vt[i].data);
                check_all($sformatf("vec%0d", i), vt[i].e_pc, vt[i].e_instr,
                          vt[i].e_valid, vt[i].e_req, vt[i].e_err);
            end
        end

        // Randomized episodes with a rising ack probability, so some end in timeout and some run long.
        for (int ep = 0; ep < 10; ep++) begin
            int pct;
            pct = 20 + ep * 8;
            async_reset_pulse($sformatf("ep%0d rst", ep));
            model_reset();
            for (int c = 0; c < 40; c++) begin
                bit          ld, sel, ack;
                logic [31:0] immed, data;
                if ($urandom_range(0, 49) == 0) begin
                    async_reset_pulse($sformatf("ep%0d c%0d rst", ep, c));
                    model_reset();
                end else begin
                    ld    = 1'($urandom_range(0, 1));
                    sel   = 1'($urandom_range(0, 1));
                    immed = $urandom;
                    ack   = ($urandom_range(0, 99) < pct);
                    data  = $urandom;
                    model_edge(ld, sel, immed, ack, data);
                    drive(ld, sel, immed, ack, data);
                    check_all($sformatf("ep%0d c%0d", ep, c), m_pc, m_instr, m_valid, m_busy, m_err);
                end
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
